bus_mem_responder: RTL and testbench

Bus-target end of the shared request/done bus used by the CPU start/fetch managers. It answers single-cycle `read_q`/`write_q` pulses aimed at its address window and services them from a local word memory. After a fixed latency it returns `read_dn`/`write_dn` plus read data. While a transaction is in flight it holds `is_bus_busy` on the shared tri-state line.

---
 rtl/bus_mem_responder_pkg.sv | 19 +
 rtl/bus_mem_array.sv | 27 ++
 rtl/bus_mem_responder.sv | 121 ++++++++++++
 tb/tb_bus_mem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared responder definitions: FSM state codes and WAIT counter sizing.
// Counter width covers the full legal LATENCY range of 1..15.
package bus_mem_responder_pkg;

  localparam int unsigned RESP_STATE_SIZE = 2;
  localparam int unsigned CNT_SIZE        = 4;

  typedef enum logic [RESP_STATE_SIZE-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } resp_state_t;

  // WAIT absorbs the whole latency, so the counter is loaded with LATENCY-1.
  function automatic logic [CNT_SIZE-1:0] cnt_load(input int unsigned latency);
    return CNT_SIZE'(latency - 1);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Single-port word RAM with registered read, used as the responder's backing store.
// Read and write share one address; only one of them is active at a time.
module bus_mem_array
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_SIZE-1:0]  i_wdata,
  output logic [DATA_SIZE-1:0]  o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_SIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// Bus target for the shared read_q/write_q request bus: window decode, fixed-latency
// FSM, local memory and registered tri-state drivers for done, data and busy.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_SIZE-1:0]      addr,
  input  logic                      read_q,
  input  logic                      write_q,
  input  logic                      rw_halt,
  inout  wire logic [DATA_SIZE-1:0] data,
  output logic                      read_dn,
  output logic                      write_dn,
  inout  wire logic                 is_bus_busy
);

  localparam logic [ADDR_SIZE:0]    WIN_LO   = (ADDR_SIZE+1)'(BASE_ADDR);
  localparam logic [ADDR_SIZE:0]    WIN_HI   = WIN_LO + (ADDR_SIZE+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] BASE_IDX = WIN_LO[DEPTH_LOG2-1:0];
  localparam logic [CNT_SIZE-1:0]   CNT_INIT = cnt_load(LATENCY);

  resp_state_t           r_state, w_state_nxt;
  logic [CNT_SIZE-1:0]   r_cnt, w_cnt_nxt;
  logic                  r_op_wr;
  logic [DEPTH_LOG2-1:0] r_index;
  logic [DATA_SIZE-1:0]  r_wdata;
  logic                  r_busy, r_read_dn, r_write_dn;

  logic                  w_rd, w_wr, w_halt, w_hit, w_accept, w_commit;
  logic [ADDR_SIZE:0]    w_addr_ext;
  logic [DEPTH_LOG2-1:0] w_index;
  logic [DATA_SIZE-1:0]  w_rdata;

  // Only a solid 1 counts; z or x on the shared lines means not asserted.
  assign w_rd   = (read_q === 1'b1);
  assign w_wr   = (write_q === 1'b1);
  assign w_halt = (rw_halt === 1'b1);

  assign w_addr_ext = {1'b0, addr};
  assign w_hit      = (w_addr_ext >= WIN_LO) && (w_addr_ext < WIN_HI);
  assign w_index    = addr[DEPTH_LOG2-1:0] - BASE_IDX;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((w_rd || w_wr) && w_hit) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (w_halt) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_ACK;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_read_dn  <= 1'b0;
      r_write_dn <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op_wr <= w_wr;
        r_index <= w_index;
        r_wdata <= data;
      end
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_read_dn  <= (w_state_nxt == ST_ACK) && !r_op_wr;
      r_write_dn <= (w_state_nxt == ST_ACK) && r_op_wr;
    end
  end

  // The edge entering ACK both commits a write and loads the RAM read register.
  bus_mem_array #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_commit && r_op_wr),
    .i_re   (w_commit && !r_op_wr),
    .i_addr (r_index),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  assign read_dn     = r_read_dn  ? 1'b1 : 1'bz;
  assign write_dn    = r_write_dn ? 1'b1 : 1'bz;
  assign is_bus_busy = r_busy     ? 1'b1 : 1'bz;
  assign data        = r_read_dn  ? w_rdata : {DATA_SIZE{1'bz}};

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: two instances (LATENCY 2 and 4, window 0x100..0x1FF)
// driven through write/read/miss/halt/reset sequences with per-cycle expectations.
module tb_bus_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] tb_wdata;
  logic        tb_doe;
  logic        rw_halt;
  logic        rq_a, wq_a, rq_b, wq_b;

  wire  [31:0] data_a, data_b;
  wire         rdn_a, wdn_a, busy_a, rdn_b, wdn_b, busy_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign data_a = tb_doe ? tb_wdata : 'z;
  assign data_b = tb_doe ? tb_wdata : 'z;

  bus_mem_responder #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH_LOG2(8), .BASE_ADDR(32'h100), .LATENCY(LAT_A)
  ) u_lat2 (
    .clk(clk), .rst(rst), .addr(addr), .read_q(rq_a), .write_q(wq_a), .rw_halt(rw_halt),
    .data(data_a), .read_dn(rdn_a), .write_dn(wdn_a), .is_bus_busy(busy_a)
  );

  bus_mem_responder #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH_LOG2(8), .BASE_ADDR(32'h100), .LATENCY(LAT_B)
  ) u_lat4 (
    .clk(clk), .rst(rst), .addr(addr), .read_q(rq_b), .write_q(wq_b), .rw_halt(rw_halt),
    .data(data_b), .read_dn(rdn_b), .write_dn(wdn_b), .is_bus_busy(busy_b)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr);
    rq_a = (sel == 0) && rd;
    wq_a = (sel == 0) && wr;
    rq_b = (sel == 1) && rd;
    wq_b = (sel == 1) && wr;
  endtask

  task automatic sample(input int sel, output logic rdn, output logic wdn,
                        output logic busy, output logic [31:0] d);
    if (sel == 0) begin
      rdn = (rdn_a === 1'b1); wdn = (wdn_a === 1'b1); busy = (busy_a === 1'b1); d = data_a;
    end else begin
      rdn = (rdn_b === 1'b1); wdn = (wdn_b === 1'b1); busy = (busy_b === 1'b1); d = data_b;
    end
  endtask

  // Window j is the cycle between edge k+j and k+j+1, where k samples the request.
  task automatic xact(input string tag, input int sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic hit,
                      input int halt_j, input int extra_j, input logic [31:0] exp_rdata);
    int          lat;
    int          last_busy;
    logic        rdn, wdn, busy;
    logic        e_busy, e_rdn, e_wdn;
    logic [31:0] dq;
    lat       = (sel == 0) ? LAT_A : LAT_B;
    last_busy = (halt_j >= 0) ? halt_j : lat;
    addr      = a;
    tb_wdata  = d;
    tb_doe    = wr;
    drive(sel, rd, wr);
    @(negedge clk);
    tb_doe = 1'b0;
    drive(sel, 1'b0, 1'b0);
    for (int j = 0; j <= lat + 1; j++) begin
      sample(sel, rdn, wdn, busy, dq);
      e_busy = hit && (j <= last_busy);
      e_rdn  = hit && !wr && (halt_j < 0) && (j == lat);
      e_wdn  = hit && wr && (halt_j < 0) && (j == lat);
      chk_bit($sformatf("%s/busy@%0d", tag, j), busy, e_busy);
      chk_bit($sformatf("%s/read_dn@%0d", tag, j), rdn, e_rdn);
      chk_bit($sformatf("%s/write_dn@%0d", tag, j), wdn, e_wdn);
      if (e_rdn) chk_word($sformatf("%s/data", tag), dq, exp_rdata);
      rw_halt = (j == halt_j);
      if (j == extra_j) begin
        addr = 32'h105;
        drive(sel, 1'b1, 1'b0);
      end else begin
        drive(sel, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    rw_halt = 1'b0;
  endtask

  initial begin
    logic        rdn, wdn, busy;
    logic [31:0] dq;
    rst = 1'b1; addr = '0; tb_wdata = '0; tb_doe = 1'b0; rw_halt = 1'b0;
    drive(0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 2; s++) begin
        sample(s, rdn, wdn, busy, dq);
        chk_bit($sformatf("idle%0d/busy@%0d", s, c), busy, 1'b0);
        chk_bit($sformatf("idle%0d/read_dn@%0d", s, c), rdn, 1'b0);
        chk_bit($sformatf("idle%0d/write_dn@%0d", s, c), wdn, 1'b0);
      end
      @(negedge clk);
    end

    xact("pre_103", 0, 1'b0, 1'b1, 32'h103, 32'h0BADF00D, 1'b1, -1, -1, '0);
    xact("pre_1ff", 0, 1'b0, 1'b1, 32'h1FF, 32'hCAFEF00D, 1'b1, -1, -1, '0);
    xact("pre_101", 0, 1'b0, 1'b1, 32'h101, 32'h11111111, 1'b1, -1, -1, '0);

    xact("wr_105",  0, 1'b0, 1'b1, 32'h105, 32'hDEADBEEF, 1'b1, -1, -1, '0);
    xact("rd_105",  0, 1'b1, 1'b0, 32'h105, '0, 1'b1, -1, -1, 32'hDEADBEEF);

    xact("rd_0ff",  0, 1'b1, 1'b0, 32'h0FF, '0, 1'b0, -1, -1, '0);
    xact("rd_200",  0, 1'b1, 1'b0, 32'h200, '0, 1'b0, -1, -1, '0);
    xact("rd_1ff",  0, 1'b1, 1'b0, 32'h1FF, '0, 1'b1, -1, -1, 32'hCAFEF00D);

    xact("both_101", 0, 1'b1, 1'b1, 32'h101, 32'h12345678, 1'b1, -1, 1, '0);
    xact("rd_101",   0, 1'b1, 1'b0, 32'h101, '0, 1'b1, -1, -1, 32'h12345678);
    xact("ack_req",  0, 1'b1, 1'b0, 32'h103, '0, 1'b1, -1, LAT_A, 32'h0BADF00D);

    xact("l4_pre_102", 1, 1'b0, 1'b1, 32'h102, 32'h55555555, 1'b1, -1, -1, '0);
    xact("l4_halt",    1, 1'b0, 1'b1, 32'h102, 32'h0000AAAA, 1'b1, 1, -1, '0);
    xact("l4_rd_102",  1, 1'b1, 1'b0, 32'h102, '0, 1'b1, -1, -1, 32'h55555555);

    addr = 32'h103;
    drive(0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    sample(0, rdn, wdn, busy, dq);
    chk_bit("rst_mid/busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample(0, rdn, wdn, busy, dq);
      chk_bit($sformatf("rst_mid/busy@%0d", c), busy, 1'b0);
      chk_bit($sformatf("rst_mid/read_dn@%0d", c), rdn, 1'b0);
      @(negedge clk);
    end
    xact("rd_103", 0, 1'b1, 1'b0, 32'h103, '0, 1'b1, -1, -1, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
